// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus controller: turns MEM-stage load/store requests into a req/ack bus
// transaction, stalls the pipeline until completion and reports a timeout as bus_err.
module dmem_bus_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] wdata,
  output logic [31:0] raw_data,
  output logic        stall_req,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;
  logic       start;
  logic       acked;
  logic       timed_out;
  logic       addr_lsb_unused;

  // The bus is word-addressed; byte offset is carried by the lane enables.
  assign addr_lsb_unused = ^addr[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    acked     = 1'b0;
    timed_out = 1'b0;
    stall_req = 1'b0;
    case (state)
      IDLE: begin
        if (mem_rd || mem_wr) begin
          start     = 1'b1;
          stall_req = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        stall_req = 1'b1;
        if (bus_ack) begin
          acked     = 1'b1;
          state_nxt = DONE;
        end else if (cnt == CNT_LAST) begin
          timed_out = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        // Stall is released here so the pipeline moves on and the request is not reissued.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_sel   <= 4'd0;
      bus_wdata <= 32'd0;
      raw_data  <= 32'd0;
      bus_err   <= 1'b0;
      cnt       <= 8'd0;
    end else begin
      if (start) begin
        bus_req   <= 1'b1;
        bus_we    <= mem_wr & ~mem_rd;
        bus_addr  <= {addr[31:2], 2'b00};
        bus_sel   <= mem_rd ? 4'b1111 : sel;
        bus_wdata <= wdata;
        cnt       <= 8'd0;
      end
      if (state == REQ) begin
        cnt <= cnt + 8'd1;
      end
      if (acked) begin
        bus_req <= 1'b0;
        if (!bus_we) begin
          raw_data <= bus_rdata;
        end
      end
      if (timed_out) begin
        bus_req <= 1'b0;
        bus_err <= 1'b1;
        if (!bus_we) begin
          raw_data <= 32'd0;
        end
      end
      if (state == DONE) begin
        bus_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Scoreboard bench for dmem_bus_ctrl: stimulus pushes the expected outcome of each
// transaction, a negedge monitor checks every completed bus transaction against it.
module tb_dmem_bus_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_rd = 1'b0;
  logic        mem_wr = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [3:0]  sel = 4'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] bus_rdata = 32'd0;
  logic        bus_ack = 1'b0;
  logic [31:0] raw_data;
  logic        stall_req;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;

  dmem_bus_ctrl #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .addr      (addr),
    .sel       (sel),
    .wdata     (wdata),
    .raw_data  (raw_data),
    .stall_req (stall_req),
    .bus_err   (bus_err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_sel   (bus_sel),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] baddr;
    logic [3:0]  bsel;
    logic [31:0] bwdata;
    int          stall;
    logic [31:0] raw;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_raw = 32'd0;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  // Monitor: a transaction completes in the cycle after bus_req falls (DONE).
  logic        req_prev = 1'b0;
  int          stall_cnt = 0;
  logic        cap_we;
  logic [31:0] cap_addr;
  logic [3:0]  cap_sel;
  logic [31:0] cap_wdata;
  logic        unstable = 1'b0;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (rst) begin
      req_prev  = 1'b0;
      stall_cnt = 0;
    end else begin
      if (stall_req) stall_cnt++;
      if (bus_req && !req_prev) begin
        cap_we    = bus_we;
        cap_addr  = bus_addr;
        cap_sel   = bus_sel;
        cap_wdata = bus_wdata;
        unstable  = 1'b0;
      end else if (bus_req) begin
        if (bus_we !== cap_we || bus_addr !== cap_addr || bus_sel !== cap_sel ||
            bus_wdata !== cap_wdata)
          unstable = 1'b1;
      end
      if (!bus_req && req_prev) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_txn: got a completed transaction, expected none");
        end else begin
          mon_e = sb.pop_front();
          check("bus_we", 32'(cap_we), 32'(mon_e.we));
          check("bus_addr", cap_addr, mon_e.baddr);
          check("bus_sel", 32'(cap_sel), 32'(mon_e.bsel));
          if (mon_e.we) check("bus_wdata", cap_wdata, mon_e.bwdata);
          check("bus_stable", 32'(unstable), 32'd0);
          check("stall_cycles", 32'(stall_cnt), 32'(mon_e.stall));
          check("raw_data", raw_data, mon_e.raw);
          check("bus_err", 32'(bus_err), 32'(mon_e.err));
        end
        stall_cnt = 0;
      end else if (bus_err) begin
        check("bus_err_outside_done", 32'(bus_err), 32'd0);
      end
      req_prev = bus_req;
    end
  end

  // d = ack delay in REQ cycles; d >= TO means the bus never acknowledges.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] wd, input int d,
                         input logic [31:0] rdat, input bit from_done);
    exp_t e;
    bit   tmo;
    int   n;
    tmo      = (d >= TO);
    n        = tmo ? TO : d + 1;
    e.we     = wr & ~rd;
    e.baddr  = {a[31:2], 2'b00};
    e.bsel   = rd ? 4'b1111 : s;
    e.bwdata = wd;
    e.stall  = 1 + n;
    e.err    = tmo;
    if (rd) model_raw = tmo ? 32'd0 : rdat;
    e.raw = model_raw;
    sb.push_back(e);
    mem_rd    = rd;
    mem_wr    = wr;
    addr      = a;
    sel       = s;
    wdata     = wd;
    bus_ack   = 1'($urandom_range(0, 1));
    bus_rdata = $urandom;
    if (from_done) @(posedge clk) #1;
    @(posedge clk) #1;
    for (int k = 0; k < n; k++) begin
      mem_rd    = 1'($urandom_range(0, 1));
      mem_wr    = 1'($urandom_range(0, 1));
      addr      = $urandom;
      sel       = 4'($urandom);
      wdata     = $urandom;
      bus_ack   = (k == d);
      bus_rdata = (k == d) ? rdat : $urandom;
      @(posedge clk) #1;
    end
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    bus_ack   = 1'($urandom_range(0, 1));
    bus_rdata = $urandom;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_raw_data", raw_data, 32'd0);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_stall_req", 32'(stall_req), 32'd0);
    check("rst_bus_we", 32'(bus_we), 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_sel", 32'(bus_sel), 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);

    run_txn(1'b1, 1'b0, 32'h0000_1003, 4'b0000, 32'd0, 0, 32'hA1B2_C3D4, 1'b0);
    run_txn(1'b0, 1'b1, 32'h0000_2002, 4'b0011, 32'h0000_BEEF, 3, 32'h5555_5555, 1'b1);
    run_txn(1'b1, 1'b1, 32'h0000_3008, 4'b0101, 32'h1234_5678, 1, 32'h0BAD_F00D, 1'b1);
    run_txn(1'b1, 1'b0, 32'h0000_4000, 4'b0000, 32'd0, TO, 32'hFFFF_FFFF, 1'b1);
    run_txn(1'b0, 1'b1, 32'h0000_4444, 4'b0000, 32'hCAFE_0000, TO + 1, 32'd0, 1'b1);

    // Reset during the second REQ cycle, followed by a late ack.
    @(posedge clk) #1;
    mem_rd = 1'b1;
    addr   = 32'h0000_5000;
    @(posedge clk) #1;
    mem_rd  = 1'b0;
    bus_ack = 1'b0;
    @(posedge clk) #1;
    rst = 1'b1;
    @(posedge clk) #1;
    model_raw = 32'd0;
    check("midrst_bus_req", 32'(bus_req), 32'd0);
    check("midrst_bus_err", 32'(bus_err), 32'd0);
    check("midrst_stall", 32'(stall_req), 32'd0);
    rst       = 1'b0;
    bus_ack   = 1'b1;
    bus_rdata = 32'hDEAD_BEEF;
    @(posedge clk) #1;
    check("late_ack_bus_req", 32'(bus_req), 32'd0);
    check("late_ack_raw", raw_data, model_raw);
    check("late_ack_stall", 32'(stall_req), 32'd0);

    // Spurious ack in IDLE, then two back-to-back loads.
    run_txn(1'b1, 1'b0, 32'h0000_6000, 4'b0000, 32'd0, 0, 32'h1111_2222, 1'b0);
    @(posedge clk) #1;
    bus_ack   = 1'b1;
    bus_rdata = 32'h7777_7777;
    repeat (2) @(posedge clk);
    #1;
    check("spurious_ack_raw", raw_data, model_raw);
    check("spurious_ack_req", 32'(bus_req), 32'd0);
    run_txn(1'b1, 1'b0, 32'h0000_7004, 4'b0000, 32'd0, 0, 32'h0102_0304, 1'b0);
    run_txn(1'b1, 1'b0, 32'h0000_7008, 4'b0000, 32'd0, 0, 32'h0506_0708, 1'b1);

    for (int i = 0; i < 200; i++) begin
      logic [1:0] op;
      bit         fd;
      op = 2'($urandom_range(1, 3));
      fd = 1'($urandom_range(0, 1));
      if (!fd) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      run_txn(op[0], op[1], $urandom, 4'($urandom), $urandom,
              int'($urandom_range(0, TO + 1)), $urandom, fd);
    end

    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
